// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder with programmable wait states and two-cycle ERROR response.
// Define AHB_SLAVE_SUBWORD_EN to allow byte/halfword transfers; otherwise only word transfers are legal.
module ahb_slave_mem #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [32:0] SPAN  = 33'(MEM_DEPTH) * 33'd4;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem [MEM_DEPTH];

    logic             w_accept;
    logic [31:0]      w_off;
    logic             w_in_range;
    logic             w_misalign;
    logic             w_err;
    logic [31:0]      w_roff;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic             w_unused;

    assign w_accept   = HSEL & HREADY & HTRANS[1];
    assign w_off      = HADDR - BASE_ADDR;
    assign w_in_range = (HADDR >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
    assign w_misalign = ((HSIZE == 3'b001) && HADDR[0]) ||
                        ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

`ifdef AHB_SLAVE_SUBWORD_EN
    assign w_err = !w_in_range || (HSIZE > 3'b010) || w_misalign;

    always_comb begin
        w_be = '0;
        case (r_size)
            3'b000:  w_be[r_addr[1:0]] = 1'b1;
            3'b001:  w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = '1;
        endcase
    end

    assign w_unused = ^{HTRANS[0], w_roff[31:IDX_W+2], w_roff[1:0]};
`else
    assign w_err    = !w_in_range || (HSIZE != 3'b010) || w_misalign;
    assign w_be     = '1;
    assign w_unused = ^{HTRANS[0], w_roff[31:IDX_W+2], w_roff[1:0], r_size};
`endif

    assign w_roff = r_addr - BASE_ADDR;
    assign w_idx  = w_roff[IDX_W+1:2];

    assign HRDATA = ((r_state == S_DATA) && !r_write) ? r_mem[w_idx] : '0;

    // Storage has no reset; a reset forces S_IDLE asynchronously, so an in-flight write never commits.
    always_ff @(posedge HCLK) begin
        if ((r_state == S_DATA) && r_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_size    <= '0;
            r_cnt     <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state   <= S_DATA;
                        r_cnt     <= '0;
                        HREADYOUT <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state   <= S_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                // IDLE, DATA and ERR2 all end with HREADYOUT=1, so each can take a new address phase.
                default: begin
                    if (w_accept) begin
                        r_addr  <= HADDR;
                        r_write <= HWRITE;
                        r_size  <= HSIZE;
                        if (w_err) begin
                            r_state   <= S_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (WS != '0) begin
                            r_state   <= S_WAIT;
                            r_cnt     <= WS;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                        end
                    end else begin
                        r_state   <= S_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
